// File: rtl/fifo_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_scan_pkg
// Description : Shared sizing helpers and scan-chain segment layout for the
//               parametrised scan FIFO.
// Revision    : 1.0  initial release
// ============================================================================
package fifo_scan_pkg;

    // Read pointer always heads the chain, directly after SI.
    localparam int C_RD_OFF = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int chain_len(input int width, input int depth);
        return 3 * clog2(depth) + 1 + width + 2;
    endfunction

    function automatic int wr_off(input int depth);
        return clog2(depth);
    endfunction

    function automatic int cnt_off(input int depth);
        return 2 * clog2(depth);
    endfunction

    function automatic int dout_off(input int depth);
        return 3 * clog2(depth) + 1;
    endfunction

    function automatic int ovf_off(input int width, input int depth);
        return 3 * clog2(depth) + 1 + width;
    endfunction

    function automatic int udf_off(input int width, input int depth);
        return 3 * clog2(depth) + 2 + width;
    endfunction

endpackage : fifo_scan_pkg
`default_nettype wire

// File: rtl/fifo_scan_param_scan_dff.sv
`default_nettype none
// ============================================================================
// Module      : scan_dff
// Description : Mux-D scan flop with synchronous active-high reset.
// Revision    : 1.0  initial release
// ============================================================================
module scan_dff (
    input  logic clk,
    input  logic rst,
    input  logic TM,
    input  logic SI,
    input  logic D,
    output logic Q
);

    always_ff @(posedge clk) begin
        if (rst) Q <= 1'b0;
        else     Q <= TM ? SI : D;
    end

endmodule : scan_dff
`default_nettype wire

// File: rtl/fifo_scan_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_scan_param
// Description : Parametrised synchronous FIFO; every control/status flop sits
//               on a single mux-D scan chain (storage array excluded).
// Revision    : 1.0  initial release
// ============================================================================
module fifo_scan_param
    import fifo_scan_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read,
    input  logic                   write,
    input  logic [WIDTH-1:0]       d_in,
    output logic [WIDTH-1:0]       d_out,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [clog2(DEPTH):0]  count,
    output logic                   ovf,
    output logic                   udf,
    input  logic                   TM,
    input  logic                   SI,
    output logic                   SO
);

    localparam int AW        = clog2(DEPTH);
    localparam int L         = chain_len(WIDTH, DEPTH);
    localparam int C_WR_OFF  = wr_off(DEPTH);
    localparam int C_CNT_OFF = cnt_off(DEPTH);
    localparam int C_DO_OFF  = dout_off(DEPTH);
    localparam int C_OVF_OFF = ovf_off(WIDTH, DEPTH);
    localparam int C_UDF_OFF = udf_off(WIDTH, DEPTH);

    localparam logic [AW:0]   C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_AF     = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   C_AE     = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0]   C_CNT_1  = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_1  = AW'(1);

    logic [L-1:0]       r_chain;
    logic [L-1:0]       w_chain_d;
    logic [L-1:0]       w_scan_in;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic [AW-1:0]      w_rd_ptr;
    logic [AW-1:0]      w_wr_ptr;
    logic [AW:0]        w_count;
    logic [WIDTH-1:0]   w_dout;
    logic               w_ovf;
    logic               w_udf;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_mem_we;
    logic [AW:0]        w_count_nxt;

    assign w_rd_ptr = r_chain[C_RD_OFF  +: AW];
    assign w_wr_ptr = r_chain[C_WR_OFF  +: AW];
    assign w_count  = r_chain[C_CNT_OFF +: AW+1];
    assign w_dout   = r_chain[C_DO_OFF  +: WIDTH];
    assign w_ovf    = r_chain[C_OVF_OFF];
    assign w_udf    = r_chain[C_UDF_OFF];

    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == C_DEPTH);

    // A full FIFO still accepts a push when the same edge pops the oldest entry.
    assign w_push   = write & (~w_full | read);
    assign w_pop    = read & ~w_empty;
    assign w_mem_we = w_push & ~TM & ~rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_wr_ptr] <= d_in;
    end

    always_comb begin
        w_count_nxt = w_count;
        if (w_push && !w_pop)      w_count_nxt = w_count + C_CNT_1;
        else if (!w_push && w_pop) w_count_nxt = w_count - C_CNT_1;
    end

    always_comb begin
        w_chain_d                         = '0;
        w_chain_d[C_RD_OFF  +: AW]        = w_pop  ? w_rd_ptr + C_PTR_1 : w_rd_ptr;
        w_chain_d[C_WR_OFF  +: AW]        = w_push ? w_wr_ptr + C_PTR_1 : w_wr_ptr;
        w_chain_d[C_CNT_OFF +: AW+1]      = w_count_nxt;
        w_chain_d[C_DO_OFF  +: WIDTH]     = w_pop  ? r_mem[w_rd_ptr] : w_dout;
        w_chain_d[C_OVF_OFF]              = w_ovf | (write & w_full & ~read);
        w_chain_d[C_UDF_OFF]              = w_udf | (read & w_empty);
    end

    // Each flop's scan input is its predecessor's output; bit 0 takes SI.
    assign w_scan_in = {r_chain[L-2:0], SI};

    generate
        for (genvar i = 0; i < L; i++) begin : g_chain
            scan_dff u_dff (
                .clk (clk),
                .rst (rst),
                .TM  (TM),
                .SI  (w_scan_in[i]),
                .D   (w_chain_d[i]),
                .Q   (r_chain[i])
            );
        end
    endgenerate

    assign d_out        = w_dout;
    assign count        = w_count;
    assign ovf          = w_ovf;
    assign udf          = w_udf;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (w_count <= C_AE);
    assign almost_full  = (w_count >= C_AF);
    assign SO           = r_chain[L-1];

endmodule : fifo_scan_param
`default_nettype wire

// File: tb/tb_fifo_scan_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_scan_param
// Description : Scoreboard bench for fifo_scan_param (default parameters).
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_scan_param;

    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int L     = 25;

    logic             clk = 1'b0;
    logic             rst, read, write, TM, SI;
    logic [WIDTH-1:0] d_in, d_out;
    logic             empty, full, almost_empty, almost_full, ovf, udf, SO;
    logic [4:0]       count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] sb_exp[$];
    bit               scan_q[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf, m_udf;

    always #5 clk = ~clk;

    fifo_scan_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .d_in(d_in), .d_out(d_out),
        .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .ovf(ovf), .udf(udf), .TM(TM), .SI(SI), .SO(SO)
    );

    // Drive one functional cycle and advance the reference model alongside it.
    task automatic step(input bit rd, input bit wr, input logic [WIDTH-1:0] data);
        bit full_m  = (m_q.size() == DEPTH);
        bit do_pop  = rd && (m_q.size() != 0);
        bit do_push = wr && (!full_m || rd);
        if (rd && m_q.size() == 0) m_udf = 1'b1;
        if (wr && full_m && !rd)   m_ovf = 1'b1;
        if (do_pop) begin
            m_dout = m_q.pop_front();
            sb_exp.push_back(m_dout);
        end
        if (do_push) m_q.push_back(data);
        read = rd; write = wr; d_in = data;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; TM = 1'b0; read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_q.delete(); sb_exp.delete(); scan_q.delete();
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({empty, full, almost_empty, almost_full, ovf, udf, SO} !== 7'b1010000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1010000", {empty, full, almost_empty, almost_full, ovf, udf, SO});
        end
        checks++;
        if (count !== 5'd0 || d_out !== '0) begin
            failures++;
            $display("FAIL reset_count_dout count=%0d d_out=%h exp 0/000", count, d_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, WIDTH'(i));
            checks++;
            if (count !== 5'(m_q.size()) || almost_full !== (i >= 14) ||
                full !== (i == DEPTH) || almost_empty !== (i <= 2) || empty !== 1'b0) begin
                failures++;
                $display("FAIL fill_%0d count=%0d af=%b f=%b ae=%b e=%b exp count=%0d af=%b f=%b ae=%b",
                         i, count, almost_full, full, almost_empty, empty, m_q.size(), i >= 14, i == DEPTH, i <= 2);
            end
        end
        step(1'b0, 1'b1, 10'h3AA);
        checks++;
        if (ovf !== m_ovf || count !== 5'd16 || m_ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow ovf=%b count=%0d exp ovf=1 count=16", ovf, count);
        end
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, '0);
            exp = sb_exp.pop_front();
            checks++;
            if (d_out !== exp || count !== 5'(m_q.size())) begin
                failures++;
                $display("FAIL drain_%0d d_out=%h count=%0d exp d_out=%h count=%0d", i, d_out, count, exp, m_q.size());
            end
        end
        checks++;
        if (empty !== 1'b1 || udf !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty empty=%b udf=%b exp 1/0", empty, udf);
        end
        step(1'b1, 1'b0, '0);
        checks++;
        if (udf !== m_udf || d_out !== 10'h010 || count !== 5'd0) begin
            failures++;
            $display("FAIL underflow udf=%b d_out=%h count=%0d exp udf=1 d_out=010 count=0", udf, d_out, count);
        end
    endtask

    task automatic test_simul();
        logic [WIDTH-1:0] exp;
        do_reset();
        step(1'b1, 1'b1, 10'h101);
        checks++;
        if (count !== 5'd1 || udf !== 1'b1 || d_out !== '0) begin
            failures++;
            $display("FAIL simul_empty count=%0d udf=%b d_out=%h exp 1/1/000", count, udf, d_out);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, WIDTH'(10'h110 + i));
        step(1'b1, 1'b1, 10'h120);
        exp = sb_exp.pop_front();
        checks++;
        if (count !== 5'd5 || d_out !== exp) begin
            failures++;
            $display("FAIL simul_mid count=%0d d_out=%h exp count=5 d_out=%h", count, d_out, exp);
        end
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, WIDTH'(10'h130 + i));
        step(1'b1, 1'b1, 10'h1FF);
        exp = sb_exp.pop_front();
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || d_out !== exp || ovf !== 1'b0) begin
            failures++;
            $display("FAIL simul_full count=%0d full=%b ovf=%b d_out=%h exp 16/1/0 d_out=%h", count, full, ovf, d_out, exp);
        end
        while (m_q.size() != 0) begin
            step(1'b1, 1'b0, '0);
            exp = sb_exp.pop_front();
            checks++;
            if (d_out !== exp) begin
                failures++;
                $display("FAIL simul_order d_out=%h exp=%h", d_out, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, WIDTH'($urandom_range(0, 1023)));
            checks++;
            if (count !== 5'd10) begin
                failures++;
                $display("FAIL wrap_count_%0d count=%0d exp=10", r, count);
            end
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 1'b0, '0);
                exp = sb_exp.pop_front();
                checks++;
                if (d_out !== exp) begin
                    failures++;
                    $display("FAIL wrap_data_%0d_%0d d_out=%h exp=%h", r, i, d_out, exp);
                end
            end
        end
        checks++;
        if (empty !== 1'b1 || udf !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end empty=%b udf=%b ovf=%b exp 1/0/0", empty, udf, ovf);
        end
    endtask

    task automatic test_scan();
        logic [WIDTH-1:0] e [5];
        logic [L-1:0]     v;
        logic [WIDTH-1:0] exp;
        bit               b, eb;
        do_reset();
        TM = 1'b1;
        for (int n = 1; n <= 2 * L; n++) begin
            b = (n % 2 == 1);
            scan_q.push_back(b);
            SI = b;
            @(posedge clk); #1;
            eb = 1'b0;
            if (scan_q.size() == L) eb = scan_q.pop_front();
            checks++;
            if (SO !== eb) begin
                failures++;
                $display("FAIL scan_shift_%0d SO=%b exp=%b", n, SO, eb);
            end
        end
        TM = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            e[k] = WIDTH'(10'h0A0 + k);
            step(1'b0, 1'b1, e[k]);
        end
        // Load rd_ptr=0, wr_ptr=3, count=3, d_out=0, ovf=udf=0 while write is held high.
        v = '0;
        v[7:4]  = 4'd3;
        v[12:8] = 5'd3;
        TM = 1'b1; write = 1'b1; d_in = 10'h3FF;
        for (int i = L - 1; i >= 0; i--) begin
            SI = v[i];
            @(posedge clk); #1;
        end
        TM = 1'b0; write = 1'b0;
        m_q.delete(); sb_exp.delete();
        for (int k = 0; k < 3; k++) m_q.push_back(e[k]);
        m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
        checks++;
        if (count !== 5'd3 || empty !== 1'b0 || almost_empty !== 1'b0 || d_out !== '0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL scan_load count=%0d e=%b ae=%b d_out=%h ovf=%b exp 3/0/0/000/0",
                     count, empty, almost_empty, d_out, ovf);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, '0);
            exp = sb_exp.pop_front();
            checks++;
            if (d_out !== exp || count !== 5'(m_q.size())) begin
                failures++;
                $display("FAIL scan_read_%0d d_out=%h count=%0d exp d_out=%h count=%0d", k, d_out, count, exp, m_q.size());
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        TM = 1'b1; SI = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; TM = 1'b0;
        checks++;
        if (count !== 5'd0 || SO !== 1'b0 || d_out !== '0 || empty !== 1'b1 || almost_empty !== 1'b1 || udf !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_scan count=%0d SO=%b d_out=%h e=%b ae=%b udf=%b exp 0/0/000/1/1/0",
                     count, SO, d_out, empty, almost_empty, udf);
        end
        m_q.delete(); sb_exp.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, WIDTH'(10'h050 + i));
        step(1'b1, 1'b0, '0);
        rst = 1'b1; write = 1'b1; read = 1'b1; d_in = 10'h2AA;
        @(posedge clk); #1;
        rst = 1'b0; write = 1'b0; read = 1'b0;
        checks++;
        if (count !== 5'd0 || full !== 1'b0 || almost_full !== 1'b0 || ovf !== 1'b0 ||
            udf !== 1'b0 || d_out !== '0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_burst count=%0d f=%b af=%b ovf=%b udf=%b d_out=%h e=%b exp 0/0/0/0/0/000/1",
                     count, full, almost_full, ovf, udf, d_out, empty);
        end
    endtask

    initial begin
        rst = 1'b0; read = 1'b0; write = 1'b0; TM = 1'b0; SI = 1'b0; d_in = '0;
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_simul();
        test_wrap();
        test_scan();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_scan_param
`default_nettype wire
